instruction_fetch_stage: RTL and testbench

- IF stage of the no-delay-slot MIPS pipeline. Sits directly upstream of the InstructionMemory ROM and feeds the IF/ID pipeline register.
- Holds the PC and drives the ROM word address. Captures the returned instruction and PC+4 into IF/ID.
- Handles stall, redirect from branch/jump/jr, and redirect flush. No delay slot, so the wrong-path fetch is squashed.

---
 rtl/instruction_fetch_stage.sv | 57 +++++
 tb/tb_instruction_fetch_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// IF stage of the no-delay-slot MIPS pipeline. It holds the PC, addresses the ROM
// and loads the IF/ID register, with stall, redirect and redirect-flush handling.
module instruction_fetch_stage #(
    parameter int          Inst_Num_BIT = 8,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    Stall,
    input  logic                    Redirect,
    input  logic [31:0]             Redirect_Target,
    output logic [Inst_Num_BIT-1:0] Inst_Address,
    input  logic [31:0]             Instruction,
    output logic [31:0]             PC,
    output logic [31:0]             IFID_Instruction,
    output logic [31:0]             IFID_PC_Plus4,
    output logic                    IFID_Valid,
    output logic                    Addr_Error,
    output logic [31:0]             Fetch_Count
);

    logic [31:0] pc_plus4;

    // The ROM is combinational, so the word address comes straight from PC.
    assign Inst_Address = PC[Inst_Num_BIT+1:2];
    assign pc_plus4     = PC + 32'd4;

    // NOTE: every piece of pipeline state uses non-blocking assignments and the
    // asynchronous reset, so a mid-run reset flushes IF/ID without waiting for an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC               <= RESET_PC;
            IFID_Instruction <= '0;
            IFID_PC_Plus4    <= '0;
            IFID_Valid       <= 1'b0;
            Addr_Error       <= 1'b0;
            Fetch_Count      <= '0;
        end else if (Redirect) begin
            // The wrong-path instruction is squashed; a misaligned target is
            // forced aligned and only flagged, so fetch keeps running.
            PC               <= {Redirect_Target[31:2], 2'b00};
            IFID_Instruction <= '0;
            IFID_PC_Plus4    <= '0;
            IFID_Valid       <= 1'b0;
            if (Redirect_Target[1:0] != 2'b00) begin
                Addr_Error <= 1'b1;
            end
        end else if (!Stall) begin
            PC               <= pc_plus4;
            IFID_Instruction <= Instruction;
            IFID_PC_Plus4    <= pc_plus4;
            IFID_Valid       <= 1'b1;
            Fetch_Count      <= Fetch_Count + 32'd1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus randomized stall and
// redirect traffic, compared each cycle against a behavioural fetch model.
module tb_instruction_fetch_stage;

    localparam int ROM_DEPTH = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [7:0]  inst_address;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] ifid_instruction;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        addr_error;
    logic [31:0] fetch_count;

    logic [31:0] rom [ROM_DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_inst, m_pc4, m_count;
    logic        m_valid, m_err;

    instruction_fetch_stage #(
        .Inst_Num_BIT(8),
        .RESET_PC    (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .Stall           (stall),
        .Redirect        (redirect),
        .Redirect_Target (redirect_target),
        .Inst_Address    (inst_address),
        .Instruction     (instruction),
        .PC              (pc),
        .IFID_Instruction(ifid_instruction),
        .IFID_PC_Plus4   (ifid_pc_plus4),
        .IFID_Valid      (ifid_valid),
        .Addr_Error      (addr_error),
        .Fetch_Count     (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input int idx);
        return (idx < ROM_DEPTH) ? rom[idx] : 32'h0;
    endfunction

    always_comb instruction = rom_word(int'(inst_address));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_count = 32'h0;
        m_valid = 1'b0; m_err = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    pc, m_pc);
        check({tag, ".iaddr"}, {24'h0, inst_address}, (m_pc / 4) % 256);
        check({tag, ".inst"},  ifid_instruction, m_inst);
        check({tag, ".pc4"},   ifid_pc_plus4, m_pc4);
        check({tag, ".valid"}, {31'h0, ifid_valid}, {31'h0, m_valid});
        check({tag, ".err"},   {31'h0, addr_error}, {31'h0, m_err});
        check({tag, ".count"}, fetch_count, m_count);
    endtask

    // One clock cycle: inputs applied at the falling edge, outputs checked #1
    // after the rising edge; the task returns at the next falling edge.
    task automatic step(input logic s, input logic r, input logic [31:0] tgt, input string tag);
        stall = s; redirect = r; redirect_target = tgt;
        @(posedge clk);
        if (r) begin
            m_pc = tgt & ~32'h3;
            m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            if (tgt % 4 != 0) m_err = 1'b1;
        end else if (!s) begin
            m_inst  = rom_word(int'((m_pc / 4) % 256));
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_count = m_count + 32'd1;
            m_pc    = m_pc + 32'd4;
        end
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    // Hold for one edge, then pulse reset low for roughly half a cycle.
    task automatic pulse_reset(input string tag);
        stall = 1'b1; redirect = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        reset = 1'b1;
        stall = 1'b0;
    endtask

    initial begin
        logic [31:0] held_count;
        for (int i = 0; i < ROM_DEPTH; i++) rom[i] = $urandom;
        rom[0]   = 32'h3C01_6165;
        rom[119] = 32'h23BD_FFF4;

        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        check(".cycle0_pc", pc, 32'h0);
        check(".cycle0_iaddr", {24'h0, inst_address}, 32'h0);

        // Reset release and first fetch
        step(1'b0, 1'b0, 32'h0, "first");
        check("first_inst", ifid_instruction, 32'h3C01_6165);
        step(1'b0, 1'b0, 32'h0, "seq");

        // Stall two cycles at PC=8
        step(1'b1, 1'b0, 32'h0, "stall1");
        step(1'b1, 1'b0, 32'h0, "stall2");
        check("stall_pc", pc, 32'h8);
        check("stall_pc4", ifid_pc_plus4, 32'h8);
        check("stall_count", fetch_count, 32'd2);
        step(1'b0, 1'b0, 32'h0, "release");
        check("release_pc", pc, 32'd12);
        check("release_count", fetch_count, 32'd3);

        // Advance to PC=0x34, then redirect to 0x1DC
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, "run");
        check("pre_redirect_pc", pc, 32'h34);
        step(1'b0, 1'b1, 32'h1DC, "redirect");
        check("redir_iaddr", {24'h0, inst_address}, 32'd119);
        check("redir_valid", {31'h0, ifid_valid}, 32'h0);
        step(1'b0, 1'b0, 32'h0, "target");
        check("target_inst", ifid_instruction, 32'h23BD_FFF4);
        check("target_pc4", ifid_pc_plus4, 32'h1E0);

        // Redirect wins over stall
        held_count = fetch_count;
        step(1'b1, 1'b1, 32'h88, "redir_stall");
        check("redir_stall_count", fetch_count, held_count);
        check("redir_stall_pc", pc, 32'h88);

        // Misaligned target sets the sticky error
        step(1'b0, 1'b1, 32'h8A, "misalign");
        check("misalign_err", {31'h0, addr_error}, 32'h1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, "sticky");
        check("sticky_err", {31'h0, addr_error}, 32'h1);
        pulse_reset("err_reset");
        check("err_cleared", {31'h0, addr_error}, 32'h0);

        // Mid-run reset at PC=0x40, Fetch_Count=16
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 32'h0, "warm");
        check("warm_pc", pc, 32'h40);
        check("warm_count", fetch_count, 32'd16);
        pulse_reset("midrun_reset");
        step(1'b0, 1'b0, 32'h0, "restart");
        check("restart_pc", pc, 32'h4);

        // PC wrap; the far address lies beyond the ROM and fetches a valid nop
        step(1'b0, 1'b1, 32'hFFFF_FFF8, "wrap_redir");
        step(1'b0, 1'b0, 32'h0, "wrap1");
        check("beyond_rom_inst", ifid_instruction, 32'h0);
        check("beyond_rom_valid", {31'h0, ifid_valid}, 32'h1);
        step(1'b0, 1'b0, 32'h0, "wrap2");
        check("wrap_pc", pc, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic        s, r;
            logic [31:0] tgt;
            s   = ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 7) == 0);
            tgt = 32'($urandom_range(0, 255)) * 4;
            if ($urandom_range(0, 15) == 0) tgt = tgt | 32'($urandom_range(1, 3));
            step(s, r, tgt, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
